// File: rtl/apb_master.sv
// apb_master: turns single-beat command-port requests into APB transfers
// across two slave selects, aborting an ACCESS phase that waits too long.
// Ports: pclk/preset clock and async active-low reset; req_* command in
// (valid/ready); rsp_* registered response; psel1/psel2/penable/pwrite/
// paddr/pwdata APB request out; pready1/2 and prdata1/2 slave returns in.
module apb_master #(
    parameter int TIMEOUT = 16
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [8:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       psel1,
    output logic       psel2,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic       pready1,
    input  logic       pready2,
    input  logic [7:0] prdata1,
    input  logic [7:0] prdata2
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       sel2;
    logic [7:0] wait_cnt;
    logic       ready_sel;
    logic [7:0] rdata_sel;
    logic       done;
    logic       expire;

    // Only the slave we selected is listened to.
    assign ready_sel = sel2 ? pready2 : pready1;
    assign rdata_sel = sel2 ? prdata2 : prdata1;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        psel1     = 1'b0;
        psel2     = 1'b0;
        penable   = 1'b0;
        done      = 1'b0;
        expire    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = SETUP;
            end
            SETUP: begin
                psel1     = ~sel2;
                psel2     = sel2;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel1   = ~sel2;
                psel2   = sel2;
                penable = 1'b1;
                // A late pready on the last allowed cycle still wins.
                if (ready_sel) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_MAX) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state     <= IDLE;
            sel2      <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= 8'h00;
            pwdata    <= 8'h00;
            wait_cnt  <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= done | expire;
            if (req_valid && req_ready) begin
                sel2     <= req_addr[8];
                pwrite   <= req_write;
                paddr    <= req_addr[7:0];
                pwdata   <= req_wdata;
                wait_cnt <= 8'h00;
            end else if (state == ACCESS && !done && !expire) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (done) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= pwrite ? 8'h00 : rdata_sel;
            end else if (expire) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized bench for apb_master with two behavioural
// APB slaves and a reference memory model.
module tb_apb_master;

    localparam int T = 16;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [8:0] req_addr = 9'h000;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       psel1, psel2, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic       pready1, pready2;
    logic [7:0] prdata1, prdata2;

    logic       t_req_valid = 1'b0;
    logic       t_req_write = 1'b0;
    logic [8:0] t_req_addr = 9'h000;
    logic [7:0] t_req_wdata = 8'h00;
    logic       t_req_ready, t_rsp_valid, t_rsp_err;
    logic [7:0] t_rsp_rdata;
    logic       t_psel1, t_psel2, t_penable, t_pwrite;
    logic [7:0] t_paddr, t_pwdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int overlap = 0;
    int a2s = 0;
    int rsp_hi = 0;
    int acc_t[$];
    logic prev_pen = 1'b0;

    logic [7:0] mem1[256];
    logic [7:0] mem2[256];
    logic [7:0] ref1[256];
    logic [7:0] ref2[256];
    int   s2_wait = 1;
    logic s2_stuck = 1'b0;
    int   cnt2;

    always #5 pclk = ~pclk;

    apb_master #(.TIMEOUT(T)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel1(psel1), .psel2(psel2), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready1(pready1), .pready2(pready2),
        .prdata1(prdata1), .prdata2(prdata2)
    );

    apb_master #(.TIMEOUT(4)) dut4 (
        .pclk(pclk), .preset(preset),
        .req_valid(t_req_valid), .req_write(t_req_write),
        .req_addr(t_req_addr), .req_wdata(t_req_wdata),
        .req_ready(t_req_ready), .rsp_valid(t_rsp_valid),
        .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
        .psel1(t_psel1), .psel2(t_psel2), .penable(t_penable),
        .pwrite(t_pwrite), .paddr(t_paddr), .pwdata(t_pwdata),
        .pready1(1'b0), .pready2(1'b0),
        .prdata1(8'hFF), .prdata2(8'hFF)
    );

    // slave1: registered pready one cycle after penable
    always @(posedge pclk or negedge preset) begin
        if (!preset) pready1 <= 1'b0;
        else pready1 <= psel1 && penable && !pready1;
    end
    always @(posedge pclk)
        if (psel1 && penable && pready1 && pwrite) mem1[paddr] <= pwdata;
    assign prdata1 = mem1[paddr];

    // slave2: pready after s2_wait ACCESS cycles, or never when stuck
    always @(posedge pclk or negedge preset) begin
        if (!preset) cnt2 <= 0;
        else if (psel2 && penable) cnt2 <= cnt2 + 1;
        else cnt2 <= 0;
    end
    assign pready2 = psel2 && penable && !s2_stuck && (cnt2 >= s2_wait);
    always @(posedge pclk)
        if (psel2 && penable && pready2 && pwrite) mem2[paddr] <= pwdata;
    assign prdata2 = mem2[paddr];

    always @(negedge pclk) begin
        cyc++;
        if (psel1 && psel2) overlap++;
        if (prev_pen && (psel1 || psel2) && !penable) a2s++;
        if (rsp_valid) rsp_hi++;
        prev_pen = penable;
    end

    always @(posedge pclk)
        if (preset && req_valid && req_ready) acc_t.push_back(cyc);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model(input logic wr, input logic [8:0] a,
                         input logic [7:0] d, output logic [7:0] xrd,
                         output logic xer, output int xlen);
        xer  = a[8] && (s2_stuck || (s2_wait + 1 > T));
        xlen = !a[8] ? 2 : (xer ? T : s2_wait + 1);
        xrd  = 8'h00;
        if (!xer) begin
            if (wr) begin
                if (a[8]) ref2[a[7:0]] = d;
                else ref1[a[7:0]] = d;
            end else begin
                xrd = a[8] ? ref2[a[7:0]] : ref1[a[7:0]];
            end
        end
    endtask

    task automatic do_xfer(input logic wr, input logic [8:0] a,
                           input logic [7:0] d, output logic [7:0] rd,
                           output logic er, output int nacc,
                           output int lat, output logic bad);
        int k;
        bad  = 1'b0;
        nacc = 0;
        @(negedge pclk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge pclk);
            k++;
        end
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            if (penable) nacc++;
            if ((psel1 || psel2) &&
                (paddr !== a[7:0] || pwrite !== wr ||
                 pwdata !== d || psel2 !== a[8])) bad = 1'b1;
            @(negedge pclk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic test_reset();
        int h;
        #1 preset = 1'b0;
        #2;
        tests++;
        if ({psel1, psel2, penable, pwrite, paddr, pwdata,
             rsp_valid, rsp_rdata, rsp_err, req_ready} !==
            {4'b0000, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_values: got %b %b %b %b %h %h %b %h %b %b",
                     psel1, psel2, penable, pwrite, paddr, pwdata,
                     rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h055;
        req_wdata = 8'h77;
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0;
        @(posedge pclk);
        #1;
        tests++;
        if ({psel1, penable} !== 2'b11) begin
            fails++;
            $display("FAIL reset_pre_access: got psel1=%b penable=%b want 11",
                     psel1, penable);
        end
        h = rsp_hi;
        #1 preset = 1'b0;
        #1;
        tests++;
        if ({psel1, psel2, penable, rsp_valid, req_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_mid_access: got %b%b%b%b%b want 00001",
                     psel1, psel2, penable, rsp_valid, req_ready);
        end
        repeat (2) @(negedge pclk);
        preset = 1'b1;
        repeat (5) @(negedge pclk);
        tests++;
        if (rsp_hi !== h) begin
            fails++;
            $display("FAIL reset_no_rsp: got %0d pulses want 0", rsp_hi - h);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] rd;
        logic er, bad;
        int n, l, h;
        h = rsp_hi;
        do_xfer(1'b1, 9'h012, 8'hA5, rd, er, n, l, bad);
        ref1[8'h12] = 8'hA5;
        tests++;
        if ({er, rd, 8'(n), 8'(l), bad} !== {1'b0, 8'h00, 8'd2, 8'd4, 1'b0}) begin
            fails++;
            $display("FAIL wr_slave1: got err=%b rd=%h acc=%0d lat=%0d bad=%b want 0 00 2 4 0",
                     er, rd, n, l, bad);
        end
        do_xfer(1'b0, 9'h012, 8'h00, rd, er, n, l, bad);
        tests++;
        if ({er, rd, 8'(n), 8'(l), bad} !== {1'b0, 8'hA5, 8'd2, 8'd4, 1'b0}) begin
            fails++;
            $display("FAIL rd_slave1: got err=%b rd=%h acc=%0d lat=%0d bad=%b want 0 a5 2 4 0",
                     er, rd, n, l, bad);
        end
        repeat (3) @(negedge pclk);
        tests++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b0, 8'hA5, 1'b0}) begin
            fails++;
            $display("FAIL rsp_hold: got v=%b rd=%h err=%b want 0 a5 0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        tests++;
        if (rsp_hi - h !== 2) begin
            fails++;
            $display("FAIL rsp_pulse_width: got %0d high cycles want 2", rsp_hi - h);
        end
    endtask

    task automatic test_decode();
        logic [7:0] rd;
        logic er, bad;
        int n, l;
        s2_wait = 1;
        do_xfer(1'b1, 9'h0F0, 8'hC3, rd, er, n, l, bad);
        ref1[8'hF0] = 8'hC3;
        do_xfer(1'b1, 9'h1F0, 8'h3C, rd, er, n, l, bad);
        ref2[8'hF0] = 8'h3C;
        do_xfer(1'b0, 9'h1F0, 8'h00, rd, er, n, l, bad);
        tests++;
        if ({er, rd, bad} !== {1'b0, 8'h3C, 1'b0}) begin
            fails++;
            $display("FAIL decode_slave2: got err=%b rd=%h bad=%b want 0 3c 0",
                     er, rd, bad);
        end
        do_xfer(1'b0, 9'h0F0, 8'h00, rd, er, n, l, bad);
        tests++;
        if ({er, rd, bad} !== {1'b0, 8'hC3, 1'b0}) begin
            fails++;
            $display("FAIL decode_slave1: got err=%b rd=%h bad=%b want 0 c3 0",
                     er, rd, bad);
        end
        tests++;
        if (overlap !== 0) begin
            fails++;
            $display("FAIL psel_overlap: got %0d cycles want 0", overlap);
        end
    endtask

    task automatic test_wait();
        logic [7:0] rd, d, xrd;
        logic er, bad, xer;
        int n, l, xl;
        int waits[3] = '{5, 15, 16};
        for (int i = 0; i < 3; i++) begin
            s2_wait = waits[i];
            d = 8'($urandom_range(1, 255));
            model(1'b1, 9'h120, d, xrd, xer, xl);
            do_xfer(1'b1, 9'h120, d, rd, er, n, l, bad);
            model(1'b0, 9'h120, 8'h00, xrd, xer, xl);
            do_xfer(1'b0, 9'h120, 8'h00, rd, er, n, l, bad);
            tests++;
            if ({er, rd, 8'(n), bad} !== {xer, xrd, 8'(xl), 1'b0}) begin
                fails++;
                $display("FAIL wait_%0d: got err=%b rd=%h acc=%0d bad=%b want %b %h %0d 0",
                         waits[i], er, rd, n, bad, xer, xrd, xl);
            end
        end
        s2_wait = 1;
    endtask

    task automatic test_timeout();
        logic [7:0] rd, d;
        logic er, bad;
        int n, l;
        s2_wait = 1;
        d = 8'($urandom_range(1, 255));
        do_xfer(1'b1, 9'h1AA, d, rd, er, n, l, bad);
        ref2[8'hAA] = d;
        do_xfer(1'b0, 9'h1AA, 8'h00, rd, er, n, l, bad);
        s2_stuck = 1'b1;
        do_xfer(1'b0, 9'h1AA, 8'h00, rd, er, n, l, bad);
        tests++;
        if ({er, rd, 8'(n), 8'(l), req_ready} !==
            {1'b1, 8'h00, 8'(T), 8'(T + 2), 1'b1}) begin
            fails++;
            $display("FAIL timeout16: got err=%b rd=%h acc=%0d lat=%0d rdy=%b want 1 00 %0d %0d 1",
                     er, rd, n, l, req_ready, T, T + 2);
        end
        s2_stuck = 1'b0;
        for (int j = 0; j < 2; j++) begin
            int k, c;
            @(negedge pclk);
            t_req_valid = 1'b1;
            t_req_write = j[0];
            t_req_addr  = (j == 0) ? 9'h1AB : 9'h0AB;
            t_req_wdata = 8'h5A;
            @(posedge pclk);
            @(negedge pclk);
            t_req_valid = 1'b0;
            c = 0;
            k = 0;
            while (!t_rsp_valid && k < 50) begin
                if (t_penable) c++;
                @(negedge pclk);
                k++;
            end
            tests++;
            if ({8'(c), t_rsp_err, t_rsp_rdata, t_req_ready, t_psel1, t_psel2} !==
                {8'd4, 1'b1, 8'h00, 1'b1, 2'b00}) begin
                fails++;
                $display("FAIL timeout4_%0d: got acc=%0d err=%b rd=%h rdy=%b sel=%b%b want 4 1 00 1 00",
                         j, c, t_rsp_err, t_rsp_rdata, t_req_ready, t_psel1, t_psel2);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, d, xrd;
        logic [8:0] a;
        logic er, bad, xer, wr;
        int n, l, xl;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            a = 9'($urandom_range(0, 15));
            a[8] = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            s2_wait = $urandom_range(0, 18);
            s2_stuck = ($urandom_range(0, 7) == 0);
            model(wr, a, d, xrd, xer, xl);
            do_xfer(wr, a, d, rd, er, n, l, bad);
            tests++;
            if ({er, rd, 8'(n), 8'(l), bad} !==
                {xer, xrd, 8'(xl), 8'(xl + 2), 1'b0}) begin
                fails++;
                $display("FAIL random_%0d: a=%h wr=%b got err=%b rd=%h acc=%0d lat=%0d bad=%b want %b %h %0d %0d 0",
                         i, a, wr, er, rd, n, l, bad, xer, xrd, xl, xl + 2);
            end
        end
        s2_wait = 1;
        s2_stuck = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[8];
        logic [7:0] rd;
        logic er, bad;
        int n, l, k, base, h, a0, gaps;
        for (int i = 0; i < 8; i++) vals[i] = 8'($urandom);
        base = acc_t.size();
        h = rsp_hi;
        a0 = a2s;
        @(negedge pclk);
        req_valid = 1'b1;
        req_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr  = 9'(i);
            req_wdata = vals[i];
            k = 0;
            do begin
                @(negedge pclk);
                k++;
            end while (acc_t.size() <= base + i && k < 20);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge pclk);
        for (int i = 0; i < 8; i++) ref1[i] = vals[i];
        tests++;
        if (acc_t.size() - base !== 8) begin
            fails++;
            $display("FAIL b2b_count: got %0d acceptances want 8", acc_t.size() - base);
        end else begin
            gaps = 0;
            for (int i = 1; i < 8; i++)
                if (acc_t[base + i] - acc_t[base + i - 1] != 4) gaps++;
            tests++;
            if (gaps !== 0) begin
                fails++;
                $display("FAIL b2b_spacing: got %0d intervals not 4 want 0", gaps);
            end
        end
        tests++;
        if ({8'(rsp_hi - h), 8'(a2s - a0)} !== {8'd8, 8'd0}) begin
            fails++;
            $display("FAIL b2b_rsp_idle: got rsp=%0d access_to_setup=%0d want 8 0",
                     rsp_hi - h, a2s - a0);
        end
        for (int i = 0; i < 8; i++) begin
            do_xfer(1'b0, 9'(i), 8'h00, rd, er, n, l, bad);
            tests++;
            if ({er, rd} !== {1'b0, ref1[i]}) begin
                fails++;
                $display("FAIL b2b_readback_%0d: got err=%b rd=%h want 0 %h",
                         i, er, rd, ref1[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
            ref1[i] = 8'h00;
            ref2[i] = 8'h00;
        end
        test_reset();
        test_write_read();
        test_decode();
        test_wait();
        test_timeout();
        test_back_to_back();
        test_random();
        tests++;
        if ({overlap, a2s} !== {32'd0, 32'd0}) begin
            fails++;
            $display("FAIL bus_protocol: got overlap=%0d access_to_setup=%0d want 0 0",
                     overlap, a2s);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
